i2c_reg_slave: RTL

- I2C slave front end of the equalizer.
- Decodes master write transactions on `scl`/`sda` into a byte-wide register-write strobe interface (`reg_addr`/`reg_data`/`reg_we`).
- The gain register bank consumes this interface to produce `gain_1`..`gain_10`.
- Supports auto-incrementing sequential writes, repeated START and open-drain ACK generation. Register read-back is an optional build feature.

---
 rtl/i2c_reg_slave.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_slave
// Description : I2C slave front end. Decodes master write transactions into
//               a byte-wide register-write strobe interface, with
//               auto-incrementing pointer, repeated START and open-drain ACK.
//               Optional build macro I2C_READ_EN adds register read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    localparam logic [3:0] c_BYTE_BITS = 4'd8;

    logic [2:0] r_scl_sync;
    logic [2:0] r_sda_sync;
    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_done;
    logic [7:0] r_ptr;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       r_reg_we;
    logic       r_sda_low;
    logic       r_busy;
    logic       w_sda_low;
    logic       w_busy_next;

    // Synchronized level ([1]) and its one-cycle-delayed copy ([2])
    wire w_scl   = r_scl_sync[1];
    wire w_scl_d = r_scl_sync[2];
    wire w_sda   = r_sda_sync[1];
    wire w_sda_d = r_sda_sync[2];

    // START/STOP need scl high on both samples so a simultaneous scl/sda edge is not a condition
    wire w_start = w_scl & w_scl_d & w_sda_d & ~w_sda;
    wire w_stop  = w_scl & w_scl_d & ~w_sda_d & w_sda;
    wire w_rise  = w_scl & ~w_scl_d & ~w_start & ~w_stop;
    wire w_fall  = ~w_scl & w_scl_d & ~w_start & ~w_stop;

    wire w_addr_hit = (r_shift[7:1] == SLAVE_ADDR);
    wire w_in_data  = (r_state == S_ADDR) || (r_state == S_REG) ||
                      (r_state == S_WDATA) || (r_state == S_RDATA);
    wire w_in_ack   = (r_state == S_ADDR_ACK) || (r_state == S_REG_ACK) ||
                      (r_state == S_WDATA_ACK) || (r_state == S_RDATA_ACK);
    wire w_full     = (r_bit_cnt == c_BYTE_BITS);

`ifdef I2C_READ_EN
    logic [7:0] r_tx;
    logic       r_mack;
`else
    logic       w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
`endif

    // Two-stage synchronizers plus edge-detect stage; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl};
            r_sda_sync <= {r_sda_sync[1:0], sda};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state: bus conditions first, then byte/ACK progress on scl falls
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = S_IDLE;
        end else if (w_start) begin
            w_state_next = S_ADDR;
        end else if (w_fall) begin
            case (r_state)
                S_ADDR: begin
                    if (w_full) begin
`ifdef I2C_READ_EN
                        w_state_next = w_addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
`else
                        w_state_next = (w_addr_hit && !r_shift[0]) ? S_ADDR_ACK : S_WAIT_STOP;
`endif
                    end
                end
`ifdef I2C_READ_EN
                S_ADDR_ACK:  w_state_next = r_shift[0] ? S_RDATA : S_REG;
                S_RDATA:     if (w_full) w_state_next = S_RDATA_ACK;
                S_RDATA_ACK: w_state_next = r_mack ? S_WAIT_STOP : S_RDATA;
`else
                S_ADDR_ACK:  w_state_next = S_REG;
`endif
                S_REG:       if (w_full) w_state_next = S_REG_ACK;
                S_REG_ACK:   w_state_next = S_WDATA;
                S_WDATA:     if (w_full) w_state_next = S_WDATA_ACK;
                S_WDATA_ACK: w_state_next = S_WDATA;
                default:     w_state_next = r_state;
            endcase
        end
    end

    // FSM outputs: sda pull-down request and busy update
    always_comb begin
        w_sda_low = (r_state == S_ADDR_ACK) || (r_state == S_REG_ACK) ||
                    (r_state == S_WDATA_ACK);
`ifdef I2C_READ_EN
        if (r_state == S_RDATA) w_sda_low = ~r_tx[7];
`endif
        w_busy_next = r_busy;
        if (w_stop) begin
            w_busy_next = 1'b0;
        end else if (r_state == S_ADDR) begin
            if (w_state_next == S_ADDR_ACK)       w_busy_next = 1'b1;
            else if (w_state_next == S_WAIT_STOP) w_busy_next = 1'b0;
        end
    end

    // Register the pin drive and busy so neither can glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sda_low <= w_sda_low;
            r_busy    <= w_busy_next;
        end
    end

    // Bit counter and receive shifter; byte_done pulses once after the 8th rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_start || (w_fall && w_in_ack)) begin
                r_bit_cnt <= 4'd0;
            end else if (w_rise && w_in_data && !w_full) begin
                r_bit_cnt   <= r_bit_cnt + 4'd1;
                r_shift     <= {r_shift[6:0], w_sda};
                r_byte_done <= (r_bit_cnt == 4'd7);
            end
        end
    end

    // Pointer and write strobe; keyed on current state so a same-cycle STOP keeps the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 8'h00;
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
            r_reg_we   <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            if (r_byte_done) begin
                case (r_state)
                    S_REG: r_ptr <= r_shift;
                    S_WDATA: begin
                        r_reg_we   <= 1'b1;
                        r_reg_addr <= r_ptr;
                        r_reg_data <= r_shift;
                        r_ptr      <= r_ptr + 8'd1;
                    end
`ifdef I2C_READ_EN
                    // Present the pointer early so reg_rdata is valid at the ACK fall
                    S_ADDR: if (w_addr_hit && r_shift[0]) r_reg_addr <= r_ptr;
                    S_RDATA: begin
                        r_ptr      <= r_ptr + 8'd1;
                        r_reg_addr <= r_ptr + 8'd1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_READ_EN
    // Transmit shifter loads at the ACK fall and advances on each following fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= 8'hFF;
            r_mack <= 1'b1;
        end else begin
            if (w_rise && (r_state == S_RDATA_ACK)) r_mack <= w_sda;
            if (w_fall) begin
                if ((r_state == S_ADDR_ACK) && r_shift[0])
                    r_tx <= reg_rdata;
                else if ((r_state == S_RDATA_ACK) && !r_mack)
                    r_tx <= reg_rdata;
                else if ((r_state == S_RDATA) && !w_full)
                    r_tx <= {r_tx[6:0], 1'b1};
            end
        end
    end
`endif

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign reg_addr = r_reg_addr;
    assign reg_data = r_reg_data;
    assign reg_we   = r_reg_we;
    assign busy     = r_busy;

endmodule
`default_nettype wire
